vstu_bresp_tracker: RTL

- Per-instruction write-burst scheduler and completion tracker for the vector store unit's AXI W/B path.
- Records, for each in-flight vector store, how many AW bursts the address generator has issued. Retires the matching B responses in order.
- Signals instruction completion to the main sequencer only when the last burst is issued and all of its B beats have returned. Any-B-completes is not used.
- Sits between the address generator, the AXI B channel and the store unit's pe_resp path.

---
 rtl/vstu_bresp_tracker_if.sv | 50 +++++
 rtl/vstu_bresp_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vstu_bresp_tracker_if.sv
// Handshake bundle between the store unit, the address generator, the AXI B channel and the
// write-response tracker. The slave modport is the tracker's view of the bundle.
interface vstu_bresp_tracker_if #(
    parameter int unsigned NrVInsn = 8
);
    localparam int unsigned IdW = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;

    // Instruction accept from the store unit
    logic           insn_valid;
    logic [IdW-1:0] insn_id;
    logic           insn_zero;
    logic           insn_ready;

    // AW burst issue from the address generator
    logic           burst_valid;
    logic           burst_last;
    logic           burst_ready;

    // AXI B channel
    logic           b_valid;
    logic [1:0]     b_resp;
    logic           b_ready;

    // Completion towards the main sequencer
    logic           done_valid;
    logic [IdW-1:0] done_id;
    logic           store_pending;
    logic           err;
    logic [IdW-1:0] err_id;

    modport slave (
        input  insn_valid, insn_id, insn_zero,
        output insn_ready,
        input  burst_valid, burst_last,
        output burst_ready,
        input  b_valid, b_resp,
        output b_ready,
        output done_valid, done_id, store_pending, err, err_id
    );

    modport master (
        output insn_valid, insn_id, insn_zero,
        input  insn_ready,
        output burst_valid, burst_last,
        input  burst_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  done_valid, done_id, store_pending, err, err_id
    );
endinterface

// File: rtl/vstu_bresp_tracker.sv
// In-order AW burst / B response tracker for the vector store unit; one queue entry per store.
// Optional sticky B-error reporting is built when VSTU_BRESP_ERR_EN is defined.
module vstu_bresp_tracker #(
    parameter int unsigned NrVInsn        = 8,
    parameter int unsigned InsnQueueDepth = 4,
    parameter int unsigned MaxOutstanding = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    vstu_bresp_tracker_if.slave bus
);
    localparam int unsigned IdW  = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
    localparam int unsigned PtrW = (InsnQueueDepth > 1) ? $clog2(InsnQueueDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OutW = ((MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1) + 1;

    typedef logic [IdW-1:0]  id_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [OutW-1:0] out_t;

    typedef struct packed {
        logic valid;
        id_t  id;
        out_t outstanding;
        logic closed;
`ifdef VSTU_BRESP_ERR_EN
        logic err;
`endif
    } entry_t;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(InsnQueueDepth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    entry_t entry_q [InsnQueueDepth];
    entry_t entry_d [InsnQueueDepth];
    ptr_t   accept_pnt_q, accept_pnt_d;
    ptr_t   open_pnt_q, open_pnt_d;
    ptr_t   commit_pnt_q, commit_pnt_d;
    cnt_t   count_q, count_d;
    logic   done_valid_q, done_valid_d;
    id_t    done_id_q, done_id_d;

    logic   insn_ready;
    logic   burst_ready;
    logic   b_ready;
    logic   accept;
    logic   burst_fire;
    logic   b_fire;
    logic   pop;
    logic   found;
    ptr_t   scan_idx;

`ifdef VSTU_BRESP_ERR_EN
    logic   err_q, err_d;
    id_t    err_id_q, err_id_d;
    logic   unused_b_resp;
    assign unused_b_resp = bus.b_resp[0];
`else
    logic   unused_b_resp;
    assign unused_b_resp = ^bus.b_resp;
`endif

    // Handshake conditions, all taken from registered state.
    assign insn_ready  = (count_q != cnt_t'(InsnQueueDepth));
    assign burst_ready = entry_q[open_pnt_q].valid && !entry_q[open_pnt_q].closed &&
                         (entry_q[open_pnt_q].outstanding != out_t'(MaxOutstanding));
    assign b_ready     = entry_q[commit_pnt_q].valid &&
                         (entry_q[commit_pnt_q].outstanding != '0);

    assign accept     = bus.insn_valid && insn_ready;
    assign burst_fire = bus.burst_valid && burst_ready;
    assign b_fire     = bus.b_valid && b_ready;

    always_comb begin
        entry_d      = entry_q;
        accept_pnt_d = accept_pnt_q;
        commit_pnt_d = commit_pnt_q;
        count_d      = count_q;
        done_valid_d = 1'b0;
        done_id_d    = '0;
        pop          = 1'b0;
        open_pnt_d   = open_pnt_q;
        found        = 1'b0;
        scan_idx     = '0;
`ifdef VSTU_BRESP_ERR_EN
        err_d        = err_q;
        err_id_d     = err_id_q;
`endif

        // A full queue blocks accept, so the accept slot never aliases open or commit.
        if (accept) begin
            entry_d[accept_pnt_q].valid       = 1'b1;
            entry_d[accept_pnt_q].id          = bus.insn_id;
            entry_d[accept_pnt_q].outstanding = '0;
            entry_d[accept_pnt_q].closed      = bus.insn_zero;
`ifdef VSTU_BRESP_ERR_EN
            entry_d[accept_pnt_q].err         = 1'b0;
`endif
            accept_pnt_d = ptr_inc(accept_pnt_q);
        end

        if (burst_fire) begin
            entry_d[open_pnt_q].outstanding = entry_d[open_pnt_q].outstanding + out_t'(1);
            if (bus.burst_last) begin
                entry_d[open_pnt_q].closed = 1'b1;
            end
        end

        // Applied after the burst update so a same-entry issue and retire cancel out.
        if (b_fire) begin
            entry_d[commit_pnt_q].outstanding = entry_d[commit_pnt_q].outstanding - out_t'(1);
`ifdef VSTU_BRESP_ERR_EN
            if (bus.b_resp[1]) begin
                entry_d[commit_pnt_q].err = 1'b1;
            end
`endif
        end

        // Retire in the same cycle as the final B so the done pulse follows it directly.
        pop = entry_q[commit_pnt_q].valid && entry_q[commit_pnt_q].closed &&
              (entry_d[commit_pnt_q].outstanding == '0);

        if (pop) begin
            entry_d[commit_pnt_q].valid = 1'b0;
            commit_pnt_d = ptr_inc(commit_pnt_q);
            done_valid_d = 1'b1;
            done_id_d    = entry_q[commit_pnt_q].id;
`ifdef VSTU_BRESP_ERR_EN
            if (entry_d[commit_pnt_q].err && !err_q) begin
                err_d    = 1'b1;
                err_id_d = entry_q[commit_pnt_q].id;
            end
`endif
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Everything older than open_pnt is closed, so the oldest open entry is the first
        // valid, unclosed slot found walking forward from it; none left means accept_pnt.
        open_pnt_d = accept_pnt_d;
        for (int unsigned i = 0; i < InsnQueueDepth; i++) begin
            scan_idx = ptr_t'((32'(open_pnt_q) + i) % InsnQueueDepth);
            if (!found && entry_d[scan_idx].valid && !entry_d[scan_idx].closed) begin
                open_pnt_d = scan_idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q      <= '{default: '0};
            accept_pnt_q <= '0;
            open_pnt_q   <= '0;
            commit_pnt_q <= '0;
            count_q      <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
        end else begin
            entry_q      <= entry_d;
            accept_pnt_q <= accept_pnt_d;
            open_pnt_q   <= open_pnt_d;
            commit_pnt_q <= commit_pnt_d;
            count_q      <= count_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
        end
    end

`ifdef VSTU_BRESP_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    assign bus.err    = err_q;
    assign bus.err_id = err_id_q;
`else
    assign bus.err    = 1'b0;
    assign bus.err_id = '0;
`endif

    assign bus.insn_ready    = insn_ready;
    assign bus.burst_ready   = burst_ready;
    assign bus.b_ready       = b_ready;
    assign bus.done_valid    = done_valid_q;
    assign bus.done_id       = done_id_q;
    assign bus.store_pending = (count_q != '0);

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= cnt_t'(InsnQueueDepth));
    a_pop_implies_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (count_q != '0));
endmodule
